status_reporter: RTL and testbench

STATUS_REPORTER -- requirements
Module: status_reporter

---
 rtl/status_reporter.sv | 121 ++++++++++++
 tb/tb_status_reporter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/status_reporter.sv
// Status reporter: on an MCU request, flushes the status register, waits (bounded) for the
// status byte, then serialises SYNC_BYTE plus the status byte as two 8N1 bytes on a registered line.
module status_reporter #(
   parameter int unsigned CLKS_PER_BIT  = 16,
   parameter int unsigned FLUSH_TIMEOUT = 8,
   parameter logic [7:0]  SYNC_BYTE     = 8'h5A
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_req_status_reporter,
   input  logic [7:0] in_status_status_reporter,
   input  logic       in_valid_status_reporter,
   output logic       out_flush_status_reporter,
   output logic       out_tx_status_reporter,
   output logic       out_busy_status_reporter,
   output logic       out_timeout_status_reporter,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      TX    = 2'd2
   } state_t;

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [7:0]  WAIT_LAST = 8'(FLUSH_TIMEOUT - 1);
   localparam logic [4:0]  IDX_LAST  = 5'd19;

   state_t      state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic [15:0] bit_cnt_q, bit_cnt_d;
   logic [4:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        timeout_q, timeout_d;
   logic [19:0] frame;
   logic [4:0]  idx_next;

   // Whole frame, index 0 goes out first: start, sync LSB-first, stop, start, status LSB-first, stop.
   assign frame    = {1'b1, shift_q, 1'b0, 1'b1, SYNC_BYTE, 1'b0};
   assign idx_next = bit_idx_q + 5'd1;

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      bit_cnt_d = bit_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (in_req_status_reporter) begin
               state_d = FLUSH;
               wait_d  = 8'd0;
            end
         end
         FLUSH: begin
            // Valid is checked first so it wins over a timeout expiring on the same edge.
            if (in_valid_status_reporter) begin
               state_d   = TX;
               shift_d   = in_status_status_reporter;
               bit_cnt_d = 16'd0;
               bit_idx_d = 5'd0;
               tx_d      = 1'b0;
            end else if (wait_q == WAIT_LAST) begin
               state_d   = IDLE;
               wait_d    = 8'd0;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         TX: begin
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = 16'd0;
               if (bit_idx_q == IDX_LAST) begin
                  state_d   = IDLE;
                  bit_idx_d = 5'd0;
                  tx_d      = 1'b1;
               end else begin
                  bit_idx_d = idx_next;
                  tx_d      = frame[idx_next];
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         wait_q    <= 8'd0;
         bit_cnt_q <= 16'd0;
         bit_idx_q <= 5'd0;
         shift_q   <= 8'd0;
         tx_q      <= 1'b1;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         bit_cnt_q <= bit_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         timeout_q <= timeout_d;
      end
   end

   assign out_flush_status_reporter   = (state_q == FLUSH);
   assign out_busy_status_reporter    = (state_q != IDLE);
   assign out_tx_status_reporter      = tx_q;
   assign out_timeout_status_reporter = timeout_q;
   assign dbg_state                   = state_q;

endmodule

// File: tb/tb_status_reporter.sv
// Directed bench for status_reporter: expected tx line values are queued when a status byte
// is offered and popped one per clock while the frame is on the wire.
module tb_status_reporter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req;
   logic [7:0] status;
   logic       valid;
   logic       flush;
   logic       tx;
   logic       busy;
   logic       timeout;
   logic [1:0] dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [0:0] exp_q[$];

   status_reporter #(
      .CLKS_PER_BIT (4),
      .FLUSH_TIMEOUT(8),
      .SYNC_BYTE    (8'h5A)
   ) dut (
      .clk                        (clk),
      .reset_n                    (rst_n),
      .in_req_status_reporter     (req),
      .in_status_status_reporter  (status),
      .in_valid_status_reporter   (valid),
      .out_flush_status_reporter  (flush),
      .out_tx_status_reporter     (tx),
      .out_busy_status_reporter   (busy),
      .out_timeout_status_reporter(timeout),
      .dbg_state                  (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: each byte is start(0), 8 data bits LSB first, stop(1); 4 clocks per bit.
   task automatic push_frame(input logic [7:0] st);
      logic [7:0] b;
      logic       bit_v;
      for (int byt = 0; byt < 2; byt++) begin
         b = (byt == 0) ? 8'h5A : st;
         for (int k = 0; k < 10; k++) begin
            if (k == 0)      bit_v = 1'b0;
            else if (k == 9) bit_v = 1'b1;
            else             bit_v = b[k-1];
            repeat (4) exp_q.push_back(bit_v);
         end
      end
   endtask

   task automatic push_literal(input logic [19:0] bits_msb_first);
      for (int i = 19; i >= 0; i--)
         repeat (4) exp_q.push_back(bits_msb_first[i]);
   endtask

   // scoreboard consumer: one expected tx value per clock
   task automatic run_frame(input string tag, input int n, input bit inject);
      logic [0:0] e;
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_exp_empty: observed tx %0b expected no further frame cycle", tag, tx);
         end else begin
            e = exp_q.pop_front();
            check({tag, "_tx"}, tx, e);
         end
         check({tag, "_busy"}, busy, 1'b1);
         check({tag, "_flush"}, flush, 1'b0);
         check({tag, "_timeout"}, timeout, 1'b0);
         if (inject) begin
            case (i)
               10: req = 1'b1;
               11: req = 1'b0;
               20: begin valid = 1'b1; status = 8'h00; end
               21: valid = 1'b0;
               50: begin req = 1'b1; valid = 1'b1; status = 8'h00; end
               52: begin req = 1'b0; valid = 1'b0; end
               default: ;
            endcase
         end
         tick();
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_flush"}, flush, 1'b0);
      check({tag, "_tx"}, tx, 1'b1);
      check({tag, "_state"}, dbg_state, 2'd0);
   endtask

   initial begin
      rst_n  = 1'b0;
      req    = 1'b0;
      status = 8'h00;
      valid  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      check("reset_timeout", timeout, 1'b0);
      rst_n = 1'b1;
      tick();
      check_idle("post_reset");

      // Frame with 0x13, valid on the 3rd flush cycle
      req = 1'b1;
      tick();
      req = 1'b0;
      check("t1_flush_c1", flush, 1'b1);
      tick();
      check("t1_flush_c2", flush, 1'b1);
      tick();
      check("t1_flush_c3", flush, 1'b1);
      valid  = 1'b1;
      status = 8'h13;
      push_literal(20'b0010110101_0110010001);
      tick();
      valid = 1'b0;
      run_frame("t1", 80, 1'b0);
      check_idle("t1_end");
      check("t1_exp_drained", exp_q.size(), 0);

      // Timeout: valid never comes
      req = 1'b1;
      tick();
      req = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         check("t2_flush", flush, 1'b1);
         check("t2_timeout_early", timeout, 1'b0);
         check("t2_tx", tx, 1'b1);
         tick();
      end
      check("t2_timeout_pulse", timeout, 1'b1);
      check_idle("t2_after");
      tick();
      check("t2_timeout_done", timeout, 1'b0);
      check_idle("t2_later");

      // Valid on the 8th flush cycle wins over the timeout
      req = 1'b1;
      tick();
      req = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         check("t3_flush", flush, 1'b1);
         tick();
      end
      check("t3_flush_c8", flush, 1'b1);
      valid  = 1'b1;
      status = 8'hFF;
      push_frame(8'hFF);
      tick();
      valid = 1'b0;
      run_frame("t3", 80, 1'b0);
      check_idle("t3_end");
      check("t3_timeout_after", timeout, 1'b0);

      // Requests and valids injected during TX are ignored
      req = 1'b1;
      tick();
      req    = 1'b0;
      valid  = 1'b1;
      status = 8'h3C;
      push_frame(8'h3C);
      tick();
      valid = 1'b0;
      run_frame("t4", 80, 1'b1);
      check_idle("t4_end");
      repeat (3) tick();
      check_idle("t4_no_second");

      // Reset at cycle 30 of TX, then a clean frame
      req = 1'b1;
      tick();
      req    = 1'b0;
      valid  = 1'b1;
      status = 8'hA7;
      push_frame(8'hA7);
      tick();
      valid = 1'b0;
      run_frame("t5_pre", 30, 1'b0);
      rst_n = 1'b0;
      #1;
      check_idle("t5_abort");
      check("t5_abort_timeout", timeout, 1'b0);
      exp_q.delete();
      tick();
      tick();
      check_idle("t5_in_reset");
      rst_n = 1'b1;
      req   = 1'b1;
      tick();
      req = 1'b0;
      check("t5_first_req", flush, 1'b1);
      tick();
      valid  = 1'b1;
      status = 8'h81;
      push_frame(8'h81);
      tick();
      valid = 1'b0;
      run_frame("t5_post", 80, 1'b0);
      check_idle("t5_end");

      // Request held high restarts on the first IDLE cycle after the frame
      req = 1'b1;
      tick();
      valid  = 1'b1;
      status = 8'h42;
      push_frame(8'h42);
      tick();
      valid = 1'b0;
      run_frame("t6", 80, 1'b0);
      check_idle("t6_gap");
      tick();
      check("t6_restart_flush", flush, 1'b1);
      req = 1'b0;
      repeat (8) tick();
      check("t6_timeout_pulse", timeout, 1'b1);
      tick();
      check_idle("t6_end");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
